// File: rtl/cr_pkt_queue_ctrl.sv
// Per-flow retransmit packet-queue controller.
// Keeps a circular queue of (sequence, tx id) pairs. Two enqueue requesters
// (req0 = loss detection, req1 = timeout) share one write port through a
// round-robin arbiter. The tx scheduler pops entries from the head.
module cr_pkt_queue_ctrl #(
    parameter int                SEQ_W    = 32,
    parameter int                TXID_W   = 8,
    parameter int                IND_W    = 4,
    parameter logic [SEQ_W-1:0]  SEQ_NONE = {SEQ_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              req0_valid,
    input  logic [SEQ_W-1:0]  req0_seq,
    input  logic [TXID_W-1:0] req0_tx_id,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [SEQ_W-1:0]  req1_seq,
    input  logic [TXID_W-1:0] req1_tx_id,
    output logic              req1_ready,
    output logic              deq_valid,
    output logic [SEQ_W-1:0]  deq_seq,
    output logic [TXID_W-1:0] deq_tx_id,
    input  logic              deq_ready,
    output logic [IND_W:0]    queue_size,
    output logic              queue_full,
    output logic              queue_empty,
    output logic [15:0]       enq_ignored_cnt
);

    localparam int             DEPTH    = 2 ** IND_W;
    localparam logic [IND_W:0] DEPTH_SZ = (IND_W + 1)'(DEPTH);

    // Queue storage; deliberately left without reset.
    logic [SEQ_W-1:0]  seq_mem  [DEPTH];
    logic [TXID_W-1:0] txid_mem [DEPTH];

    // Control state.
    logic [IND_W-1:0] head_q, head_d;
    logic [IND_W-1:0] tail_q, tail_d;
    logic [IND_W:0]   size_q, size_d;
    logic             rr_q, rr_d;       // 0: req0 wins a tie, 1: req1 wins
    logic [15:0]      ign_cnt_q, ign_cnt_d;

    // Datapath intermediates.
    logic              arb_en;
    logic              grant0;
    logic              grant1;
    logic              enq_fire;
    logic              enq_none;
    logic              enq_wr;
    logic              deq_fire;
    logic [SEQ_W-1:0]  enq_seq;
    logic [TXID_W-1:0] enq_tx_id;

    // Status flags come straight from the registered occupancy.
    always_comb begin
        queue_full  = (size_q == DEPTH_SZ);
        queue_empty = (size_q == '0);
        queue_size  = size_q;
    end

    // Round-robin arbitration; readies are held low while in reset so that
    // no transfer can be seen as accepted during an abort.
    always_comb begin
        arb_en    = rst_n & ~flush & ~queue_full;
        grant0    = arb_en & req0_valid & (~req1_valid | ~rr_q);
        grant1    = arb_en & req1_valid & (~req0_valid |  rr_q);
        enq_fire  = grant0 | grant1;
        enq_seq   = grant1 ? req1_seq   : req0_seq;
        enq_tx_id = grant1 ? req1_tx_id : req0_tx_id;
        enq_none  = (enq_seq == SEQ_NONE);
        enq_wr    = enq_fire & ~enq_none;
        req0_ready = grant0;
        req1_ready = grant1;
    end

    // Dequeue view of the head entry; data forced to zero when not valid.
    always_comb begin
        deq_valid = ~queue_empty & ~flush;
        deq_fire  = deq_valid & deq_ready;
        deq_seq   = '0;
        deq_tx_id = '0;
        if (deq_valid) begin
            deq_seq   = seq_mem[head_q];
            deq_tx_id = txid_mem[head_q];
        end
    end

    // Next-state for pointers, occupancy, arbiter pointer and ignore counter.
    always_comb begin
        head_d    = head_q;
        tail_d    = tail_q;
        size_d    = size_q;
        rr_d      = rr_q;
        ign_cnt_d = ign_cnt_q;

        if (flush) begin
            // Flush wins over everything; arbiter and counter survive it.
            head_d = '0;
            tail_d = '0;
            size_d = '0;
        end else begin
            if (enq_wr) begin
                tail_d = tail_q + 1'b1;
            end
            if (deq_fire) begin
                head_d = head_q + 1'b1;
            end
            unique case ({enq_wr, deq_fire})
                2'b10:   size_d = size_q + 1'b1;
                2'b01:   size_d = size_q - 1'b1;
                default: size_d = size_q;
            endcase
        end

        // The next tie goes to whoever did not get this grant.
        if (enq_fire) begin
            rr_d = grant0;
        end

        if (enq_fire && enq_none && (ign_cnt_q != 16'hFFFF)) begin
            ign_cnt_d = ign_cnt_q + 16'd1;
        end
    end

    // Control registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            size_q    <= '0;
            rr_q      <= 1'b0;
            ign_cnt_q <= '0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            size_q    <= size_d;
            rr_q      <= rr_d;
            ign_cnt_q <= ign_cnt_d;
        end
    end

    // Storage write at the tail on a real (non-null) enqueue.
    always_ff @(posedge clk) begin
        if (enq_wr) begin
            seq_mem[tail_q]  <= enq_seq;
            txid_mem[tail_q] <= enq_tx_id;
        end
    end

    assign enq_ignored_cnt = ign_cnt_q;

endmodule

// File: doc/cr_pkt_queue_ctrl.md
Name: cr_pkt_queue_ctrl

Overview:
Per-flow retransmit packet-queue controller. It owns the circular packet/tx-id queue context and serialises two enqueue requesters onto a single enqueue write path per cycle:
- req0: loss-detection (NACK/SACK-driven)
- req1: timeout-driven

It also serves one dequeue consumer, the tx scheduler, that pops sequences for retransmission. It sits between the event processors and the tx path, and exposes occupancy and status.

Parameters:
SEQ_W, 32, flow sequence number width
TXID_W, 8, transmission-count (tx id) width
IND_W, 4, queue index width; depth DEPTH = 2**IND_W
SEQ_NONE, {SEQ_W{1'b1}}, null-sequence encoding; enqueue of this value is a no-op

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous queue clear
req0_valid  in  1  loss-detection enqueue request
req0_seq  in  SEQ_W  sequence to enqueue
req0_tx_id  in  TXID_W  tx id of that sequence
req0_ready  out  1  req0 accepted this cycle
req1_valid  in  1  timeout enqueue request
req1_seq  in  SEQ_W  sequence to enqueue
req1_tx_id  in  TXID_W  tx id
req1_ready  out  1  req1 accepted this cycle
deq_valid  out  1  head entry available
deq_seq  out  SEQ_W  head sequence
deq_tx_id  out  TXID_W  head tx id
deq_ready  in  1  consumer pops head
queue_size  out  IND_W+1  current occupancy 0..DEPTH
queue_full  out  1  size == DEPTH
queue_empty  out  1  size == 0
enq_ignored_cnt  out  16  saturating count of accepted SEQ_NONE enqueues

Behaviour:
- Reset (async, rst_n=0) clears:
  - head, tail and size to 0
  - rr_ptr to 0 (req0 favoured)
  - enq_ignored_cnt to 0
  - Outputs at reset: deq_valid=0, deq_seq=0, deq_tx_id=0, queue_empty=1, queue_full=0, req*_ready=0.
  - Queue storage is not reset.
- Storage: DEPTH-entry seq array and DEPTH-entry tx-id array, indexed by head/tail (IND_W bits, wrap modulo DEPTH). Size is tracked in a separate IND_W+1-bit register, so full and empty are unambiguous.
- Arbitration: at most one enqueue per cycle.
  - Eligible when ~flush & ~queue_full.
  - If exactly one req*_valid is high, grant it.
  - If both are high, grant the requester rr_ptr selects (0→req0, 1→req1); rr_ptr then toggles to the loser.
  - A single-requester grant sets rr_ptr to the other requester.
  - req*_ready is combinational: high only for the granted requester when its valid is high. Transfer occurs on valid & ready.
  - Requesters hold valid and data stable until ready.
- Enqueue write:
  - On transfer with seq != SEQ_NONE: write seq and tx_id at tail, tail <= tail+1 (wrap), size +1.
  - On transfer with seq == SEQ_NONE: consume the request, leave storage, tail and size unchanged, increment enq_ignored_cnt (saturates at 16'hFFFF).
- Dequeue:
  - deq_valid = ~queue_empty & ~flush.
  - deq_seq/deq_tx_id show the head entry when valid, 0 otherwise.
  - On deq_valid & deq_ready: head <= head+1 (wrap), size -1.
- Latency:
  - An enqueued entry becomes visible on deq one cycle after acceptance.
  - There is no empty-queue bypass.
- Simultaneous enqueue (non-NONE) and dequeue: head and tail both advance, size unchanged.
- Full:
  - Both readies are 0, even if deq_ready is high the same cycle (no full-queue pass-through).
  - Readies return the cycle after size < DEPTH.
- Flush (synchronous, highest priority): head, tail and size <= 0 next edge. During the flush cycle readies=0 and deq_valid=0. rr_ptr and enq_ignored_cnt are kept.
- Mid-operation reset aborts all transfers immediately. Requesters must re-present.
- queue_size, queue_full and queue_empty are derived from registered state only.

Test Plan:
- Reset, then req0 enqueues seq=0x10/tx=1 → req0_ready=1 that cycle; next cycle deq_valid=1, deq_seq=0x10, deq_tx_id=1, queue_size=1.
- req0 and req1 both valid every cycle with distinct seqs, deq_ready=0 → grants alternate req0, req1, req0…; after 16 grants queue_full=1, both readies 0, size=16.
- Fill to 16, then pop all with deq_ready=1 → deq_seq stream matches enqueue order. Continue 20 more enq/deq pairs so head/tail wrap → order preserved, size stays constant during simultaneous enq+deq.
- req1 enqueues SEQ_NONE (0xFFFFFFFF) → req1_ready=1, queue_size unchanged, enq_ignored_cnt=1, no deq_valid.
- Queue holding 5 entries, assert flush for one cycle while req0_valid=1 → req0_ready=0, deq_valid=0 that cycle; next cycle size=0, empty=1; req0 is accepted the cycle after.
- Drop rst_n mid-stream with size=7 → outputs return to reset values asynchronously; after release, size=0 and rr_ptr favours req0.
